// File: rtl/decode_priv_fault_sequencer_pkg.sv
// rtl/decode_priv_fault_sequencer_pkg.sv - shared opcodes, IRQ number and FSM encodings
package decode_priv_fault_sequencer_pkg;

  localparam logic [6:0] L_PARAM_IRQ_NUM = 7'd41;

  // Opcodes live in instruction bits [30:21]
  localparam logic [9:0] FAULT_INSTRUCTION_SRTISR  = 10'h140;
  localparam logic [9:0] FAULT_INSTRUCTION_SRKPDTR = 10'h141;
  localparam logic [9:0] FAULT_INSTRUCTION_SRPDTW  = 10'h142;
  localparam logic [9:0] FAULT_INSTRUCTION_SRIEIW  = 10'h143;
  localparam logic [9:0] FAULT_INSTRUCTION_SRTISW  = 10'h144;
  localparam logic [9:0] FAULT_INSTRUCTION_SRKPDTW = 10'h145;
  localparam logic [9:0] FAULT_INSTRUCTION_SRMMUW  = 10'h146;
  localparam logic [9:0] FAULT_INSTRUCTION_HALT    = 10'h150;
  localparam logic [9:0] FAULT_INSTRUCTION_IDTS    = 10'h151;

  typedef enum logic [1:0] {
    L_PARAM_FSEQ_RUN        = 2'd0,
    L_PARAM_FSEQ_IRQ_REQ    = 2'd1,
    L_PARAM_FSEQ_FLUSH_WAIT = 2'd2
  } fseq_state_e;

  function automatic logic is_priv_opcode(input logic [9:0] op);
    return op inside {FAULT_INSTRUCTION_SRTISR, FAULT_INSTRUCTION_SRKPDTR,
                      FAULT_INSTRUCTION_SRPDTW, FAULT_INSTRUCTION_SRIEIW,
                      FAULT_INSTRUCTION_SRTISW, FAULT_INSTRUCTION_SRKPDTW,
                      FAULT_INSTRUCTION_SRMMUW, FAULT_INSTRUCTION_HALT,
                      FAULT_INSTRUCTION_IDTS};
  endfunction

endpackage

// File: rtl/decode_priv_fault_sequencer_if.sv
// rtl/decode_priv_fault_sequencer_if.sv - upstream, downstream, flush and IRQ signal bundle
interface decode_priv_fault_sequencer_if #(
  parameter int unsigned P_CNT_W = 16
);
  logic                 iEVENT_FLUSH;
  logic                 iPREV_VALID;
  logic [31:0]          iPREV_INST;
  logic [31:0]          iPREV_PC;
  logic                 iPREV_KERNEL;
  logic                 oPREV_LOCK;
  logic                 oNEXT_VALID;
  logic [31:0]          oNEXT_INST;
  logic [31:0]          oNEXT_PC;
  logic                 iNEXT_LOCK;
  logic                 oIRQ_REQ;
  logic [6:0]           oIRQ_NUM;
  logic [31:0]          oIRQ_PC;
  logic                 iIRQ_ACK;
  logic [P_CNT_W-1:0]   oFAULT_CNT;

  modport slave (
    input  iEVENT_FLUSH, iPREV_VALID, iPREV_INST, iPREV_PC, iPREV_KERNEL,
           iNEXT_LOCK, iIRQ_ACK,
    output oPREV_LOCK, oNEXT_VALID, oNEXT_INST, oNEXT_PC, oIRQ_REQ, oIRQ_NUM,
           oIRQ_PC, oFAULT_CNT
  );

  modport master (
    output iEVENT_FLUSH, iPREV_VALID, iPREV_INST, iPREV_PC, iPREV_KERNEL,
           iNEXT_LOCK, iIRQ_ACK,
    input  oPREV_LOCK, oNEXT_VALID, oNEXT_INST, oNEXT_PC, oIRQ_REQ, oIRQ_NUM,
           oIRQ_PC, oFAULT_CNT
  );
endinterface

// File: rtl/decode_priv_check.sv
// rtl/decode_priv_check.sv - combinational user-mode privileged-opcode screen
module decode_priv_check
  import decode_priv_fault_sequencer_pkg::*;
(
  input  logic [9:0] opcode,
  input  logic       kernel,
  output logic       fault
);

  assign fault = ~kernel & is_priv_opcode(opcode);

endmodule

// File: rtl/decode_priv_fault_sequencer.sv
// rtl/decode_priv_fault_sequencer.sv - decode pipeline register that diverts user-mode
// privileged instructions into an IRQ request / flush-wait sequence
module decode_priv_fault_sequencer
  import decode_priv_fault_sequencer_pkg::*;
#(
  parameter logic [6:0]  P_IRQ_NUM = L_PARAM_IRQ_NUM,
  parameter int unsigned P_CNT_W   = 16
)(
  input  logic                           iCLOCK,
  input  logic                           iRESET_SYNC,
  decode_priv_fault_sequencer_if.slave   bus
);

  fseq_state_e         state_q, state_d;
  logic                next_valid_q, next_valid_d;
  logic [31:0]         next_inst_q, next_inst_d;
  logic [31:0]         next_pc_q, next_pc_d;
  logic                irq_req_q, irq_req_d;
  logic [6:0]          irq_num_q, irq_num_d;
  logic [31:0]         irq_pc_q, irq_pc_d;
  logic [P_CNT_W-1:0]  fault_cnt_q, fault_cnt_d;

  logic                hold;
  logic                lock;
  logic                accept;
  logic                fault;
  logic [P_CNT_W-1:0]  cnt_inc;

  decode_priv_check u_check (
    .opcode (bus.iPREV_INST[30:21]),
    .kernel (bus.iPREV_KERNEL),
    .fault  (fault)
  );

  assign hold    = next_valid_q & bus.iNEXT_LOCK;
  assign lock    = (state_q != L_PARAM_FSEQ_RUN) | hold;
  assign accept  = bus.iPREV_VALID & ~lock;
  assign cnt_inc = (&fault_cnt_q) ? fault_cnt_q : fault_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    next_valid_d = next_valid_q;
    next_inst_d  = next_inst_q;
    next_pc_d    = next_pc_q;
    irq_req_d    = irq_req_q;
    irq_num_d    = irq_num_q;
    irq_pc_d     = irq_pc_q;
    fault_cnt_d  = fault_cnt_q;

    // Output register drains whenever downstream is not stalling it
    if (!hold) next_valid_d = 1'b0;

    if (bus.iEVENT_FLUSH) begin
      next_valid_d = 1'b0;
      state_d      = L_PARAM_FSEQ_RUN;
      if (state_q == L_PARAM_FSEQ_IRQ_REQ) begin
        irq_req_d = 1'b0;
        irq_num_d = '0;
        if (bus.iIRQ_ACK) fault_cnt_d = cnt_inc;
      end
    end else begin
      case (state_q)
        L_PARAM_FSEQ_RUN: begin
          if (accept && !fault) begin
            next_valid_d = 1'b1;
            next_inst_d  = bus.iPREV_INST;
            next_pc_d    = bus.iPREV_PC;
          end else if (accept) begin
            irq_req_d = 1'b1;
            irq_num_d = P_IRQ_NUM;
            irq_pc_d  = bus.iPREV_PC;
            state_d   = L_PARAM_FSEQ_IRQ_REQ;
          end
        end
        L_PARAM_FSEQ_IRQ_REQ: begin
          if (bus.iIRQ_ACK) begin
            irq_req_d   = 1'b0;
            irq_num_d   = '0;
            fault_cnt_d = cnt_inc;
            state_d     = L_PARAM_FSEQ_FLUSH_WAIT;
          end
        end
        L_PARAM_FSEQ_FLUSH_WAIT: ;
        default: state_d = L_PARAM_FSEQ_RUN;
      endcase
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q      <= L_PARAM_FSEQ_RUN;
      next_valid_q <= 1'b0;
      next_inst_q  <= '0;
      next_pc_q    <= '0;
      irq_req_q    <= 1'b0;
      irq_num_q    <= '0;
      irq_pc_q     <= '0;
      fault_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      next_valid_q <= next_valid_d;
      next_inst_q  <= next_inst_d;
      next_pc_q    <= next_pc_d;
      irq_req_q    <= irq_req_d;
      irq_num_q    <= irq_num_d;
      irq_pc_q     <= irq_pc_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign bus.oPREV_LOCK  = lock;
  assign bus.oNEXT_VALID = next_valid_q;
  assign bus.oNEXT_INST  = next_inst_q;
  assign bus.oNEXT_PC    = next_pc_q;
  assign bus.oIRQ_REQ    = irq_req_q;
  assign bus.oIRQ_NUM    = irq_num_q;
  assign bus.oIRQ_PC     = irq_pc_q;
  assign bus.oFAULT_CNT  = fault_cnt_q;

endmodule
